// File: rtl/spi_arbiter_if.sv
// Link between the arbiter and the shared SPI_top instance: start/busy
// handshake, per-transaction word configuration and the MOSI/MISO words.
interface spi_arbiter_if;
    logic        spi_start;
    logic        spi_busy;
    logic [1:0]  spi_mode;
    logic [1:0]  spi_speed;
    logic [1:0]  spi_len;
    logic [31:0] spi_wdata;
    logic [31:0] spi_rdata;

    // arbiter side
    modport master (
        output spi_start, spi_mode, spi_speed, spi_len, spi_wdata,
        input  spi_busy, spi_rdata
    );

    // SPI_top side
    modport slave (
        input  spi_start, spi_mode, spi_speed, spi_len, spi_wdata,
        output spi_busy, spi_rdata
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI_top between N_REQ requesters.
// Latches the winner's config/word, pulses start, follows busy and returns
// the MISO word with a one-cycle done strobe (error strobe on start timeout).
module spi_arbiter #(
    parameter int N_REQ    = 4,
    parameter int START_TO = 16
) (
    input  logic                 GCLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     req_in,
    input  logic [6*N_REQ-1:0]   req_cfg_in,
    input  logic [32*N_REQ-1:0]  req_wdata_in,
    output logic [N_REQ-1:0]     gnt_out,
    output logic [N_REQ-1:0]     done_out,
    output logic                 err_out,
    output logic [31:0]          rdata_out,
    spi_arbiter_if.master        spi
);

    localparam int              PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]      TO_LIM  = 8'(START_TO);
    localparam logic [PW-1:0]   PTR_RST = PW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_XFER      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gidx_q, gidx_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               start_q, start_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         speed_q, speed_d;
    logic [1:0]         len_q, len_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [7:0]         cnt_q, cnt_d;

    logic               sel_found_s;
    logic [PW-1:0]      sel_idx_s;
    logic [PW-1:0]      cand_s;
    logic [7:0]         cnt_inc_s;
    logic [5:0]         cfg_a   [N_REQ];
    logic [31:0]        wdata_a [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign cfg_a[gi]   = req_cfg_in[6*gi +: 6];
        assign wdata_a[gi] = req_wdata_in[32*gi +: 32];
    end

    // Timeout counter increment that sticks at its maximum instead of wrapping
    assign cnt_inc_s = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + 8'd1);

    // Rotating-priority pick: first requesting index above the last one served
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = PW'((32'(ptr_q) + 32'(i)) % 32'(N_REQ));
            if (!sel_found_s && req_in[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // State register and all datapath/output flops, synchronous reset
    always_ff @(posedge GCLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            gidx_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            start_q <= 1'b0;
            mode_q  <= 2'd0;
            speed_q <= 2'd0;
            len_q   <= 2'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; busy is only looked at in WAIT_BUSY and XFER
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (spi.spi_busy) begin
                    state_d = S_XFER;
                end else if (cnt_inc_s >= TO_LIM) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_XFER: begin
                if (spi.spi_busy) begin
                    state_d = S_XFER;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values; strobes are set on the edge entering DONE
    always_comb begin
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        start_d = 1'b0;
        mode_d  = mode_q;
        speed_d = speed_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    gnt_d   = ONE_HOT0 << sel_idx_s;
                    gidx_d  = sel_idx_s;
                    start_d = 1'b1;
                    mode_d  = cfg_a[sel_idx_s][5:4];
                    speed_d = cfg_a[sel_idx_s][3:2];
                    len_d   = cfg_a[sel_idx_s][1:0];
                    wdata_d = wdata_a[sel_idx_s];
                end else begin
                    gnt_d = '0;
                end
            end
            S_START: begin
                cnt_d = 8'd0;
            end
            S_WAIT_BUSY: begin
                if (spi.spi_busy) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s >= TO_LIM) begin
                        done_d  = gnt_q;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        err_d = 1'b0;
                    end
                end
            end
            S_XFER: begin
                if (spi.spi_busy) begin
                    done_d = '0;
                end else begin
                    done_d  = gnt_q;
                    rdata_d = spi.spi_rdata;
                end
            end
            S_DONE: begin
                gnt_d = '0;
                ptr_d = gidx_q;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign gnt_out       = gnt_q;
    assign done_out      = done_q;
    assign err_out       = err_q;
    assign rdata_out     = rdata_q;
    assign spi.spi_start = start_q;
    assign spi.spi_mode  = mode_q;
    assign spi.spi_speed = speed_q;
    assign spi.spi_len   = len_q;
    assign spi.spi_wdata = wdata_q;

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one `SPI_top` instance between `N_REQ` independent requesters. It grants one requester at a time and drives that requester's word configuration and MOSI word into `SPI_top`. It issues the start pulse and tracks `busy_out` through the transaction, then returns the captured MISO word with a one-cycle done strobe. Frame-timing parameters (IFG, CS→SCK, SCK→CS) are shared and pass straight through; per-requester fields are mode, speed, word length and data.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `START_TO`, 16: cycles to wait for `busy_out` rise after start before aborting, 1..255.

Ports:
- `GCLK` in 1: single clock for all logic.
- `RST` in 1: reset, synchronous, active-high.
- `req_in` in N_REQ: per-requester request level; hold until own `done_out` bit.
- `req_cfg_in` in 6*N_REQ: per-requester config, slice i = {mode[1:0], speed[1:0], len[1:0]} at bits [6i+5:6i].
- `req_wdata_in` in 32*N_REQ: per-requester MOSI word, slice i at [32i+31:32i].
- `gnt_out` out N_REQ: one-hot grant, held for the whole transaction.
- `done_out` out N_REQ: one-hot, one-cycle completion strobe.
- `err_out` out 1: one-cycle strobe, coincident with `done_out`, on start timeout.
- `rdata_out` out 32: MISO word of the last completed transaction; held until the next completion.
- `spi_start` out 1: to `SPI_top.start_in`.
- `spi_busy` in 1: from `SPI_top.busy_out`.
- `spi_mode`, `spi_speed`, `spi_len` out 2 each: to `SPI_top` config inputs.
- `spi_wdata` out 32: to `SPI_top.mosi_data_in`.
- `spi_rdata` in 32: from `SPI_top.miso_data_out`.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, XFER, DONE.
- IDLE, with any `req_in` bit set:
  - Select the first set bit scanning upward from `ptr+1` (mod N_REQ).
  - Register the grant, latch that requester's cfg and wdata into the `spi_*` output registers, and go to START.
- START:
  - `spi_start`=1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - `spi_busy`=1 → XFER.
  - Otherwise increment the counter. When the counter reaches `START_TO`, set the abort flag and go to DONE.
- XFER:
  - Stay while `spi_busy`=1.
  - On `spi_busy`=0, capture `spi_rdata` into `rdata_out` and go to DONE.
- DONE:
  - `done_out[g]`=1 for the granted index g. `err_out`=abort flag, and on abort `rdata_out` is loaded with 0.
  - Clear `gnt_out`, set `ptr`=g, go to IDLE.
- Config/data outputs are held constant from START through DONE. Requester inputs are ignored after latching.
- Round-robin pointer `ptr` resets to N_REQ-1, so requester 0 has first priority after reset.
- A requester dropping `req_in` mid-transaction is ignored: the transaction completes and `done_out` still pulses.
- Simultaneous requests are resolved only by the rotating priority. No requester waits more than N_REQ-1 transactions.
- `spi_busy` already high in IDLE (stale) has no effect. Only WAIT_BUSY/XFER sample it.

## Timing
- Reset values:
  - state=IDLE, `ptr`=N_REQ-1.
  - `gnt_out`, `done_out`, `err_out`, `spi_start` = 0.
  - `rdata_out`, `spi_wdata`, `spi_mode`, `spi_speed`, `spi_len` = 0.
  - Timeout counter 0.
- Reset asserted in any state returns to IDLE on the next edge with all the values above. No done strobe is emitted for the aborted transaction.
- `req_in` sampled in IDLE at edge t:
  - `gnt_out` and `spi_start` high in cycle t+1.
  - WAIT_BUSY from t+2.
- `spi_busy` seen low in XFER at edge k:
  - DONE in cycle k+1 (`done_out`, `rdata_out` valid).
  - IDLE at k+2.
  - Next grant earliest at k+3.
- Timeout: DONE occurs `START_TO`+1 cycles after START.
- The timeout counter is 8 bits and saturates; it never wraps.
- All outputs are registered.

## Test plan
- Single request: requester 2 with cfg mode=1, speed=2, len=3 and wdata 0xA5A5_1234; a `SPI_top` model with loopback → `spi_start` pulses once, config outputs match, `rdata_out`=0xA5A5_1234, `done_out`=4'b0100, `err_out`=0.
- Contention: all four `req_in` held high → grants in order 0,1,2,3,0; each `gnt_out` is one-hot and never overlaps the next.
- Fairness after service: requester 1 served, then requests 0 and 1 arrive together → requester 0 is granted before 1 (pointer rotated past 1).
- Timeout: `spi_busy` held at 0, `START_TO`=16 → DONE 17 cycles after START, `err_out`=1, `rdata_out`=0, and the next request is serviced normally.
- Reset mid-XFER: `RST` pulsed while `spi_busy`=1 → next cycle `gnt_out`=0, state IDLE, no `done_out` pulse; after release, requester 0 has priority.
- Request dropped mid-transaction: `req_in[3]` deasserted during XFER → transaction completes, `done_out[3]` still pulses, and no new grant goes to 3.
